// File: rtl/dm_lsu.sv
// dm_lsu: load/store initiator between the CPU memory stage and the byte-addressed
// data memory. Accepts one request at a time, checks alignment and range, issues
// a single-cycle memory access, then returns extended load data or an error.
// Optional statistics counters are enabled with the macro DM_LSU_STATS_EN.
module dm_lsu #(
  parameter int DM_BYTES = 2048,
  parameter int STAT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] err_addr,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  output logic        dm_re,
  output logic [1:0]  dm_sbhw,
  input  logic [31:0] dm_rdata
`ifdef DM_LSU_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_loads,
  output logic [STAT_W-1:0] stat_stores,
  output logic [STAT_W-1:0] stat_errs
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_t;

  state_t      state_reg, state_next;
  logic        we_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic [31:0] err_addr_reg;

  logic        req_bad;
  logic [1:0]  bytes_m1;
  logic [32:0] last_byte;
  logic        ext_sign;
  logic [31:0] load_ext;

  // Elaboration guard on the configuration parameters
  if (STAT_W < 1 || DM_BYTES < 4) begin : g_param_check
    $error("dm_lsu: STAT_W must be >= 1 and DM_BYTES >= 4");
  end

  // Request legality: size code, natural alignment, and last byte inside memory
  // (33-bit sum so an address that wraps past 2^32 is treated as out of range)
  always_comb begin
    bytes_m1 = 2'd3;
    case (req_size)
      2'b00:   bytes_m1 = 2'd0;
      2'b01:   bytes_m1 = 2'd1;
      default: bytes_m1 = 2'd3;
    endcase
    last_byte = {1'b0, req_addr} + {31'b0, bytes_m1};
    req_bad   = (req_size == 2'b10)
             || (req_size == 2'b01 && req_addr[0])
             || (req_size == 2'b11 && req_addr[1:0] != 2'b00)
             || (last_byte >= 33'(DM_BYTES));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state and strobes, all decoded from the registered state
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    dm_we      = 1'b0;
    dm_re      = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_bad ? ERR : ISSUE;
      end
      ISSUE: begin
        dm_we      = we_reg;
        dm_re      = !we_reg;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sign/zero extension of the memory read data for the latched size
  always_comb begin
    ext_sign = 1'b0;
    load_ext = dm_rdata;
    case (size_reg)
      2'b00: begin
        ext_sign = !uns_reg && dm_rdata[7];
        load_ext = {{24{ext_sign}}, dm_rdata[7:0]};
      end
      2'b01: begin
        ext_sign = !uns_reg && dm_rdata[15];
        load_ext = {{16{ext_sign}}, dm_rdata[15:0]};
      end
      default: load_ext = dm_rdata;
    endcase
  end

  // Request latch at acceptance; load data captured on the closing edge of ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg       <= 1'b0;
      size_reg     <= 2'b00;
      uns_reg      <= 1'b0;
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
      rdata_reg    <= 32'h0;
      err_addr_reg <= 32'h0;
    end else begin
      if (state_reg == IDLE && req_valid) begin
        we_reg    <= req_we;
        size_reg  <= req_size;
        uns_reg   <= req_unsigned;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        rdata_reg <= 32'h0;
        if (req_bad) err_addr_reg <= req_addr;
      end
      if (state_reg == ISSUE && !we_reg) rdata_reg <= load_ext;
    end
  end

  assign dm_addr    = addr_reg;
  assign dm_wdata   = wdata_reg;
  assign dm_sbhw    = size_reg;
  assign resp_rdata = rdata_reg;
  assign err_addr   = err_addr_reg;

`ifdef DM_LSU_STATS_EN
  logic [2:0] stat_inc;
  assign stat_inc = {state_reg == ERR,
                     state_reg == RESP && we_reg,
                     state_reg == RESP && !we_reg};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [STAT_W-1:0] cnt_reg;
    // Saturating event counter
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                cnt_reg <= '0;
      else if (stat_inc[gi] && cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign stat_loads  = g_stat[0].cnt_reg;
  assign stat_stores = g_stat[1].cnt_reg;
  assign stat_errs   = g_stat[2].cnt_reg;
`endif

endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: table-driven and randomized bench for dm_lsu with a byte-array data
// memory and a transaction-level reference model of the memory contents.
module tb_dm_lsu;
  localparam int DM_BYTES = 2048;
  localparam int STAT_W   = 16;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, err_addr;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_we, dm_re;
  logic [1:0]  dm_sbhw;
`ifdef DM_LSU_STATS_EN
  logic [STAT_W-1:0] stat_loads, stat_stores, stat_errs;
`endif

  dm_lsu #(.DM_BYTES(DM_BYTES), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .err_addr(err_addr), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re), .dm_sbhw(dm_sbhw),
    .dm_rdata(dm_rdata)
`ifdef DM_LSU_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- data memory environment ----------------
  logic [7:0] mem [DM_BYTES];
  logic [7:0] ref_mem [DM_BYTES];
  bit         mem_init = 1'b0;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  function automatic int mi(input logic [31:0] a);
    return int'(a % DM_BYTES);
  endfunction

  always_comb dm_rdata = {mem[mi(dm_addr + 3)], mem[mi(dm_addr + 2)],
                          mem[mi(dm_addr + 1)], mem[mi(dm_addr)]};

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DM_BYTES; i++) mem[i] <= pat(i);
      mem_init <= 1'b1;
    end else if (dm_we) begin
      mem[mi(dm_addr)] <= dm_wdata[7:0];
      if (dm_sbhw != 2'b00) mem[mi(dm_addr + 1)] <= dm_wdata[15:8];
      if (dm_sbhw == 2'b11) begin
        mem[mi(dm_addr + 2)] <= dm_wdata[23:16];
        mem[mi(dm_addr + 3)] <= dm_wdata[31:24];
      end
    end
  end

  // ---------------- scoring ----------------
  int checks = 0;
  int passes = 0;
  int n_ld = 0, n_st = 0, n_err = 0;
  int txn_no = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: plain byte arithmetic over ref_mem
  function automatic void model_txn(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    output logic err, output logic [31:0] rdata);
    longint unsigned a = addr;
    int n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    longint v = 0;
    err   = (size == 2'b10) || (a % n != 0) || (a + n > DM_BYTES);
    rdata = 32'h0;
    if (err) n_err++;
    else if (we) begin
      n_st++;
      for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = 8'(wdata >> (8 * k));
    end else begin
      n_ld++;
      for (int k = 0; k < n; k++) v += longint'(ref_mem[int'(a) + k]) << (8 * k);
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
      rdata = 32'(v);
    end
  endfunction

  // One request through the handshake, observing a 4-cycle window after acceptance
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata);
    int w = 0, lat = 0, nvalid = 0, nwe = 0, nre = 0;
    logic g_err = 1'b0;
    logic [31:0] g_rdata = 32'h0, g_eaddr = 32'h0, g_daddr = 32'h0;
    logic [1:0] g_sbhw = 2'b00;
    logic [31:0] g_wdata = 32'h0;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    while (!req_ready && w < 10) begin @(posedge clk); #1; w++; end
    check32("ready_wait", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (dm_we) begin nwe++; g_wdata = dm_wdata; end
      if (dm_re) nre++;
      if (dm_we || dm_re) begin g_daddr = dm_addr; g_sbhw = dm_sbhw; end
      if (resp_valid) begin
        nvalid++;
        if (lat == 0) begin lat = c; g_err = resp_err; g_rdata = resp_rdata; g_eaddr = err_addr; end
      end
      @(posedge clk); #1;
    end
    txn_no++;
    $display("txn %0d we=%0d size=%0d uns=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d",
             txn_no, we, size, uns, addr, wdata, g_err, g_rdata, lat);
    check32("resp_count", nvalid, 32'd1);
    check32("latency", lat, exp_err ? 32'd1 : 32'd2);
    check32("resp_err", {31'b0, g_err}, {31'b0, exp_err});
    check32("resp_rdata", g_rdata, exp_rdata);
    check32("we_pulses", nwe, (!exp_err && we) ? 32'd1 : 32'd0);
    check32("re_pulses", nre, (!exp_err && !we) ? 32'd1 : 32'd0);
    if (exp_err) check32("err_addr", g_eaddr, addr);
    else begin
      check32("dm_addr", g_daddr, addr);
      check32("dm_sbhw", {30'b0, g_sbhw}, {30'b0, size});
      if (we) check32("dm_wdata", g_wdata, wdata);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        m_err;
    logic [31:0] m_rdata;
    logic [8:0]  rdy_bits, vld_bits;
    int          bad, nv;

    for (int i = 0; i < DM_BYTES; i++) ref_mem[i] = pat(i);
    tbl[0]  = '{1'b1, 2'b11, 1'b0, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 2'b11, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 2'b00, 1'b0, 32'h21,       32'hAAAAAA80, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h21,       32'h0,        1'b0, 32'hFFFFFF80};
    tbl[4]  = '{1'b0, 2'b00, 1'b1, 32'h21,       32'h0,        1'b0, 32'h00000080};
    tbl[5]  = '{1'b1, 2'b01, 1'b0, 32'h22,       32'h55558001, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 32'h22,       32'h0,        1'b0, 32'hFFFF8001};
    tbl[7]  = '{1'b0, 2'b01, 1'b1, 32'h22,       32'h0,        1'b0, 32'h00008001};
    tbl[8]  = '{1'b0, 2'b11, 1'b0, 32'h13,       32'h0,        1'b1, 32'h0};
    tbl[9]  = '{1'b1, 2'b01, 1'b0, 32'h07,       32'h12345678, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        1'b1, 32'h0};
    tbl[11] = '{1'b1, 2'b11, 1'b0, 32'h7FE,      32'h11111111, 1'b1, 32'h0};
    tbl[12] = '{1'b1, 2'b11, 1'b0, 32'h7FC,      32'hCAFEF00D, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 2'b00, 1'b1, 32'h7FF,      32'h0,        1'b0, 32'h000000CA};
    tbl[14] = '{1'b0, 2'b01, 1'b0, 32'h7FE,      32'h0,        1'b0, 32'hFFFFCAFE};
    tbl[15] = '{1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0};
    tbl[16] = '{1'b0, 2'b11, 1'b1, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
    tbl[17] = '{1'b0, 2'b11, 1'b0, 32'h7FC,      32'h0,        1'b0, 32'hCAFEF00D};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_ready", {31'b0, req_ready}, 32'd1);
    check32("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check32("rst_resp_rdata", resp_rdata, 32'h0);
    check32("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check32("rst_err_addr", err_addr, 32'h0);
    check32("rst_dm_we", {31'b0, dm_we}, 32'd0);
    check32("rst_dm_re", {31'b0, dm_re}, 32'd0);
    check32("rst_dm_addr", dm_addr, 32'h0);
    check32("rst_dm_wdata", dm_wdata, 32'h0);
    check32("rst_dm_sbhw", {30'b0, dm_sbhw}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 18; i++) begin
      model_txn(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, m_err, m_rdata);
      run_txn(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
              tbl[i].exp_err, tbl[i].exp_rdata);
    end

    // req_valid held: three back-to-back word loads from 0x10
    for (int i = 0; i < 3; i++) model_txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, m_err, m_rdata);
    req_we = 1'b0; req_size = 2'b11; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    rdy_bits = '0; vld_bits = '0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      rdy_bits[k] = req_ready;
      vld_bits[k] = resp_valid;
      if (resp_valid) check32("b2b_rdata", resp_rdata, m_rdata);
    end
    req_valid = 1'b0;
    $display("txn b2b ready=%b resp_valid=%b", rdy_bits, vld_bits);
    check32("b2b_ready_pattern", {23'b0, rdy_bits}, 32'b100100100);
    check32("b2b_valid_pattern", {23'b0, vld_bits}, 32'b010010010);
    repeat (2) @(posedge clk);
    #1;

    // Randomized requests against the reference model
    for (int i = 0; i < 40; i++) begin
      logic        r_we, r_uns;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wdata;
      int          r;
      r       = $urandom_range(0, 9);
      r_we    = 1'($urandom_range(0, 1));
      r_uns   = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_wdata = $urandom;
      if (r < 7)      r_addr = $urandom_range(0, 127);
      else if (r < 9) r_addr = 32'(DM_BYTES - 8 + $urandom_range(0, 7));
      else            r_addr = $urandom;
      model_txn(r_we, r_size, r_uns, r_addr, r_wdata, m_err, m_rdata);
      run_txn(r_we, r_size, r_uns, r_addr, r_wdata, m_err, m_rdata);
    end

`ifdef DM_LSU_STATS_EN
    check32("stat_loads", 32'(stat_loads), 32'(n_ld));
    check32("stat_stores", 32'(stat_stores), 32'(n_st));
    check32("stat_errs", 32'(stat_errs), 32'(n_err));
`endif

    // Reset during ISSUE of a store to 0x40
    req_we = 1'b1; req_size = 2'b11; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check32("issue_dm_we", {31'b0, dm_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check32("rst_drops_dm_we", {31'b0, dm_we}, 32'd0);
    check32("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) nv++;
      @(posedge clk); #1;
    end
    $display("txn rst_mid_issue addr=00000040 responses=%0d", nv);
    check32("rst_no_resp", nv, 32'd0);
    check32("rst_mem_40", {mem[16'h43], mem[16'h42], mem[16'h41], mem[16'h40]},
            {ref_mem[16'h43], ref_mem[16'h42], ref_mem[16'h41], ref_mem[16'h40]});
`ifdef DM_LSU_STATS_EN
    check32("stat_loads_rst", 32'(stat_loads), 32'd0);
    check32("stat_stores_rst", 32'(stat_stores), 32'd0);
    check32("stat_errs_rst", 32'(stat_errs), 32'd0);
`endif

    // Whole memory image must match the model (errors never wrote)
    bad = 0;
    for (int i = 0; i < DM_BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
    check32("mem_image_mismatches", bad, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
